// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: one multiplier walks the TAPS-entry sample history per
// input, then rounds, scales and saturates the sum into a held output register.
module fir_serial_mac #(
   parameter int DATA_W = 10,
   parameter int COEF_W = 10,
   parameter int TAPS   = 63,
   parameter int SHIFT  = 9,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  out_data,
   output logic                      out_sat,
   output logic                      busy
);
   localparam int ADDR_W = $clog2(TAPS);
   localparam int CNT_W  = $clog2(TAPS + 1);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(TAPS - 1);
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(TAPS);
   localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2 ** (SHIFT - 1));
   localparam logic signed [ACC_W:0] MAX_OUT = (ACC_W+1)'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W:0] MIN_OUT = (ACC_W+1)'(-(2 ** (DATA_W - 1)));

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                    state_q, state_d;
   logic                      init_q;
   logic [ADDR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [PROD_W-1:0]  prod_q;
   logic signed [DATA_W-1:0]  out_data_q;
   logic                      out_sat_q;
   logic signed [DATA_W-1:0]  hist_q [TAPS];
   logic signed [COEF_W-1:0]  coef_q [TAPS];

   logic                      accept, mac_last, coef_wr;
   logic [ADDR_W-1:0]         k_idx, rd_ptr_dec;
   logic signed [PROD_W-1:0]  prod_d;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W:0]     acc_ext, rnd_t;
   logic signed [DATA_W-1:0]  sat_data;
   logic                      sat_flag;

   // in_ready is held low through reset and comes up on the first edge after it.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      mac_last  = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy     = 1'b0;
            in_ready = init_q;
            accept   = init_q && in_valid;
            if (accept) state_d = StMac;
         end
         StMac: begin
            mac_last = (cnt_q == LAST_CNT);
            if (mac_last) state_d = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign coef_wr  = (state_q == StIdle) && coef_we &&
                     ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS));
   assign out_data = out_data_q;
   assign out_sat  = out_sat_q;

   // Product is registered, so MAC spans TAPS+1 cycles: cycle 0 only multiplies,
   // cycle TAPS only accumulates and the final sum goes straight to the output.
   assign k_idx      = (cnt_q != LAST_CNT) ? cnt_q[ADDR_W-1:0] : '0;
   assign rd_ptr_dec = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - ADDR_W'(1);
   assign prod_d     = PROD_W'(hist_q[rd_ptr_q]) * PROD_W'(coef_q[k_idx]);
   assign acc_sum    = acc_q + ACC_W'(prod_q);
   assign acc_ext    = (ACC_W+1)'(acc_sum);
   assign rnd_t      = (acc_ext + RND) >>> SHIFT;

   always_comb begin
      sat_flag = 1'b0;
      sat_data = rnd_t[DATA_W-1:0];
      if (rnd_t > MAX_OUT) begin
         sat_flag = 1'b1;
         sat_data = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (rnd_t < MIN_OUT) begin
         sat_flag = 1'b1;
         sat_data = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         init_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         prod_q     <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         if (coef_wr) coef_q[coef_addr] <= coef_data;
         if (accept) begin
            hist_q[wr_ptr_q] <= in_data;
            rd_ptr_q         <= wr_ptr_q;
            wr_ptr_q         <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_W'(1);
            cnt_q            <= '0;
            acc_q            <= '0;
         end else if (state_q == StMac) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!mac_last) begin
               prod_q   <= prod_d;
               rd_ptr_q <= rd_ptr_dec;
            end
            if (cnt_q != '0) acc_q <= acc_sum;
            if (mac_last) begin
               out_data_q <= sat_data;
               out_sat_q  <= sat_flag;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: a 4-tap/SHIFT=1 instance and a default instance, checked
// against a sum-of-products model over the full sample sequence since reset.
module tb_fir_serial_mac;
   logic              clk = 1'b0;
   logic              rst_n;
   logic              vld [2];
   logic              rdy [2];
   logic              cwe [2];
   logic              ov  [2];
   logic              sat [2];
   logic              bsy [2];
   logic signed [9:0] od  [2];
   logic signed [9:0] din;
   logic signed [9:0] cdata;
   logic [5:0]        caddr;
   logic              oready;

   int     total = 0;
   int     bad   = 0;
   longint mh [2][63];
   longint mx [2][$];
   int     exp4 [5] = '{1, 2, 3, 4, 0};

   always #5 clk = ~clk;

   fir_serial_mac #(.DATA_W(10), .COEF_W(10), .TAPS(4), .SHIFT(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din),
      .coef_we(cwe[0]), .coef_addr(caddr[1:0]), .coef_data(cdata), .out_valid(ov[0]),
      .out_ready(oready), .out_data(od[0]), .out_sat(sat[0]), .busy(bsy[0]));

   fir_serial_mac dut63 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din),
      .coef_we(cwe[1]), .coef_addr(caddr), .coef_data(cdata), .out_valid(ov[1]),
      .out_ready(oready), .out_data(od[1]), .out_sat(sat[1]), .busy(bsy[1]));

   function automatic int taps_of(input int d);
      return (d != 0) ? 63 : 4;
   endfunction

   function automatic int shift_of(input int d);
      return (d != 0) ? 9 : 1;
   endfunction

   function automatic int rnd10();
      return int'($urandom_range(1023)) - 512;
   endfunction

   // y[n] = sat(round(sum h[k]*x[n-k]) >> SHIFT), samples before reset are zero.
   function automatic void model_out(input int d, output longint y, output longint s);
      longint acc = 0;
      longint t;
      int     n = mx[d].size();
      for (int k = 0; k < taps_of(d); k++)
         if (n - 1 - k >= 0) acc += mh[d][k] * mx[d][n-1-k];
      t = (acc + (longint'(1) <<< (shift_of(d) - 1))) >>> shift_of(d);
      if (t > 511) begin
         y = 511; s = 1;
      end else if (t < -512) begin
         y = -512; s = 1;
      end else begin
         y = t; s = 0;
      end
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         mx[d].delete();
         for (int k = 0; k < 63; k++) mh[d][k] = 0;
      end
   endtask

   task automatic wcoef(input int d, input int addr, input int val);
      @(negedge clk);
      cwe[d] = 1'b1;
      caddr  = 6'(addr);
      cdata  = 10'(val);
      @(negedge clk);
      cwe[d] = 1'b0;
      if (addr < taps_of(d)) mh[d][addr] = val;
   endtask

   // mode 1: write h[0]=cval on the accept edge; mode 2: write h[TAPS-1]=cval mid-MAC.
   task automatic run(input int d, input int x, input int hold, input int mode,
                      input int cval, input string tag, output longint oy,
                      output longint os);
      longint ey, es;
      int     lat;
      @(negedge clk);
      chk({tag, " in_ready"}, longint'(rdy[d]), 1);
      oready = (hold == 0);
      din    = 10'(x);
      vld[d] = 1'b1;
      if (mode == 1) begin
         cwe[d] = 1'b1; caddr = '0; cdata = 10'(cval);
      end
      @(posedge clk); #1;
      vld[d] = 1'b0;
      cwe[d] = 1'b0;
      mx[d].push_back(x);
      if (mode == 1) mh[d][0] = cval;
      model_out(d, ey, es);
      lat = 0;
      while (!ov[d] && lat < 200) begin
         if (mode == 2 && lat == 2) begin
            cwe[d] = 1'b1; caddr = 6'(taps_of(d) - 1); cdata = 10'(cval);
         end else begin
            cwe[d] = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      cwe[d] = 1'b0;
      chk({tag, " latency"}, lat, taps_of(d) + 1);
      oy = od[d];
      os = longint'(sat[d]);
      chk({tag, " out_data"}, oy, ey);
      chk({tag, " out_sat"}, os, es);
      for (int i = 0; i < hold; i++) begin
         vld[d] = 1'b1;
         din    = 10'(rnd10());
         @(posedge clk); #1;
         chk({tag, " hold data"}, od[d], ey);
         chk({tag, " hold sat"}, longint'(sat[d]), es);
         chk({tag, " hold valid"}, longint'(ov[d]), 1);
         chk({tag, " hold in_ready"}, longint'(rdy[d]), 0);
      end
      vld[d] = 1'b0;
      oready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " busy after out"}, longint'(bsy[d]), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint y, s;
      int     seen;
      rst_n = 1'b0;
      vld   = '{1'b0, 1'b0};
      cwe   = '{1'b0, 1'b0};
      din   = '0;
      caddr = '0;
      cdata = '0;
      oready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset in_ready[%0d]", d), longint'(rdy[d]), 0);
         chk($sformatf("reset out_valid[%0d]", d), longint'(ov[d]), 0);
         chk($sformatf("reset busy[%0d]", d), longint'(bsy[d]), 0);
         chk($sformatf("reset out_data[%0d]", d), od[d], 0);
         chk($sformatf("reset out_sat[%0d]", d), longint'(sat[d]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready after reset", longint'(rdy[0] & rdy[1]), 1);

      // Impulse on the 4-tap instance.
      for (int k = 0; k < 4; k++) wcoef(0, k, 2 * (k + 1));
      for (int i = 0; i < 5; i++) begin
         run(0, (i == 0) ? 1 : 0, 0, 0, 0, $sformatf("impulse[%0d]", i), y, s);
         chk($sformatf("impulse lit[%0d]", i), y, exp4[i]);
         chk($sformatf("impulse sat[%0d]", i), s, 0);
      end

      // Saturation both ways on the default instance.
      for (int k = 0; k < 63; k++) wcoef(1, k, 511);
      for (int i = 0; i < 63; i++) run(1, 511, 0, 0, 0, $sformatf("pos[%0d]", i), y, s);
      chk("pos sat final data", y, 511);
      chk("pos sat final flag", s, 1);
      for (int i = 0; i < 63; i++) run(1, -512, 0, 0, 0, $sformatf("neg[%0d]", i), y, s);
      chk("neg sat final data", y, -512);
      chk("neg sat final flag", s, 1);

      // Rounding at the half-LSB boundary.
      wcoef(1, 0, 256);
      for (int k = 1; k < 63; k++) wcoef(1, k, 0);
      run(1, 1, 0, 0, 0, "round 256", y, s);
      chk("round 256 lit", y, 1);
      wcoef(1, 0, 255);
      run(1, 1, 0, 0, 0, "round 255", y, s);
      chk("round 255 lit", y, 0);

      // Random coefficients and samples; address 63 must be ignored.
      for (int k = 0; k < 63; k++) wcoef(1, k, rnd10());
      wcoef(1, 63, rnd10());
      for (int i = 0; i < 15; i++) run(1, rnd10(), 0, 0, 0, $sformatf("rnd63[%0d]", i), y, s);
      for (int k = 0; k < 4; k++) wcoef(0, k, rnd10());
      for (int i = 0; i < 15; i++) run(0, rnd10(), 0, 0, 0, $sformatf("rnd4[%0d]", i), y, s);

      // Backpressure, then coefficient gating mid-MAC and on the accept edge.
      run(0, rnd10(), 10, 0, 0, "backpressure", y, s);
      run(0, rnd10(), 0, 0, 0, "after backpressure", y, s);
      run(0, rnd10(), 0, 2, 77, "coef mid-mac", y, s);
      run(0, rnd10(), 0, 0, 0, "after mid-mac", y, s);
      run(0, rnd10(), 0, 1, -100, "coef on accept", y, s);
      run(0, rnd10(), 0, 0, 0, "after accept write", y, s);

      // Reset during MAC cycle 20 of the default instance.
      @(negedge clk);
      din    = 10'(1);
      vld[1] = 1'b1;
      @(posedge clk); #1;
      vld[1] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid reset in_ready", longint'(rdy[1]), 0);
      chk("mid reset out_valid", longint'(ov[1]), 0);
      chk("mid reset busy", longint'(bsy[1]), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      @(posedge clk); #1;
      chk("mid reset ready next edge", longint'(rdy[1]), 1);
      seen = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (ov[1]) seen++;
      end
      chk("no output after reset", seen, 0);
      run(1, 1, 0, 0, 0, "post-reset impulse", y, s);
      chk("post-reset lit", y, 0);
      run(0, 1, 0, 0, 0, "post-reset impulse4", y, s);
      chk("post-reset lit4", y, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 10, signed sample width, input and output.
- COEF_W, 10, signed coefficient width.
- TAPS, 63, filter length; minimum 2.
- SHIFT, 9, output right-shift (scaling); minimum 1.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, input sample offered.
- in_ready, out, 1, block can accept a sample.
- in_data, in, DATA_W, signed input sample.
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, $clog2(TAPS), coefficient index k.
- coef_data, in, COEF_W, signed coefficient h[k].
- out_valid, out, 1, result available.
- out_ready, in, 1, downstream accepts the result.
- out_data, out, DATA_W, signed filtered sample.
- out_sat, out, 1, out_data was clipped; qualified by out_valid.
- busy, out, 1, state is not IDLE.

Function
REQ-003 The block SHALL compute y[n] = sat(round(sum over k=0..TAPS-1 of h[k]*x[n-k]) >>> SHIFT) using one multiplier, time-multiplexed.
REQ-004 Sample history SHALL be a TAPS-entry circular buffer:
- Write pointer wraps from TAPS-1 to 0.
- x[n-k] is read at (newest_ptr - k) mod TAPS.
REQ-005 The FSM SHALL have three states, IDLE, MAC and OUT, with these transitions:
- IDLE -> MAC on in_valid && in_ready.
- MAC -> OUT after exactly TAPS accumulate cycles.
- OUT -> IDLE on out_ready.
REQ-006 in_ready SHALL be 1 only in IDLE.
- An accepted sample is written to the history on the accepting edge.
- The accumulator clears to 0 on the same edge.
REQ-007 MAC SHALL add one product h[k]*x[n-k] per cycle, for k = 0 to TAPS-1 in order.
- The product is a full-precision signed multiply.
- The sum uses ACC_W-bit signed arithmetic, with no intermediate truncation.
REQ-008 On entry to OUT, the block SHALL register out_data and out_sat:
- Form t = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
- If t > 2^(DATA_W-1)-1, out_data = max positive and out_sat = 1.
- If t < -2^(DATA_W-1), out_data = max negative and out_sat = 1.
- Otherwise out_data = t[DATA_W-1:0] and out_sat = 0.
REQ-009 Latency SHALL be fixed: out_valid asserts exactly TAPS+1 cycles after the accepting edge.
REQ-010 out_valid SHALL be 1 only in OUT.
- While out_valid=1 and out_ready=0, out_data and out_sat SHALL hold stable.
REQ-011 Throughput SHALL be at most one sample per TAPS+2 cycles when out_ready is held at 1.
REQ-012 A coefficient write (coef_we=1) SHALL take effect only in IDLE.
- Writes in MAC or OUT SHALL be ignored.
REQ-013 If coef_we and an accepted in_valid occur on the same IDLE edge, the new coefficient SHALL be used in that sample's computation.
REQ-014 coef_addr >= TAPS SHALL be ignored.
REQ-015 in_data SHALL be ignored when in_ready=0; samples are never dropped or overwritten.

Reset
REQ-016 On rst_n=0, at any time including mid-MAC or OUT, the block SHALL set:
- state to IDLE;
- all history entries, all coefficients, acc and the write pointer to 0;
- out_valid=0, out_data=0, out_sat=0, busy=0 and in_ready=0.
REQ-017 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge onward.
- Any in-flight computation SHALL be discarded without producing an output.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Impulse (TAPS=4, SHIFT=1, h={2,4,6,8}): x = 1,0,0,0,0 -> out_data = 1,2,3,4,0; out_sat = 0.
- Positive saturation (defaults, all h=511): x=511 applied 63 times -> final out_data=511, out_sat=1.
- Negative saturation (defaults, all h=511): x=-512 applied 63 times -> final out_data=-512, out_sat=1.
- Rounding (defaults, h[0]=256, rest 0): x=1 -> out_data=1.
- Rounding (defaults, h[0]=255, rest 0): x=1 -> out_data=0.
- Latency and backpressure: accept at cycle 0 -> out_valid at cycle TAPS+1; hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, a second in_valid is not accepted.
- Coefficient gating: coef_we during MAC -> no effect on the current or following output.
- Coefficient gating: coef_we on the accept edge -> the new value is used.
- Reset mid-MAC: rst_n pulsed at MAC cycle 20 -> no out_valid; next impulse yields all-zero output (coefficients cleared); in_ready=1 the cycle after deassert.
